// File: rtl/se_fc_sequencer.sv
// Sequences FC1 then FC2 fully-connected layers: issues 32-wide chunks to the
// adder tree, tracks returned neuron sums and writes them back by index.
//
// state     | meaning
// IDLE      | waiting for start, cfg checked on request
// FC1_ISSUE | issuing FC1 chunks, collecting FC1 sums
// FC1_DRAIN | all FC1 chunks issued, waiting for remaining sums
// FC2_ISSUE | issuing FC2 chunks, collecting FC2 sums
// FC2_DRAIN | all FC2 chunks issued, waiting for remaining sums
// FINISH    | one-cycle done pulse
module se_fc_sequencer #(
   parameter int NEUR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4:0]        cfg_fc1_chunks,
   input  logic [2:0]        cfg_fc2_chunks,
   input  logic [NEUR_W-1:0] cfg_fc1_neurons,
   input  logic [NEUR_W-1:0] cfg_fc2_neurons,
   input  logic              feed_ready,
   input  logic              data_valid,
   output logic              fully_1,
   output logic              fully_2,
   output logic [4:0]        fc1_max_loop,
   output logic [2:0]        fc2_max_loop,
   output logic              start_adder,
   output logic [NEUR_W-1:0] feed_neuron,
   output logic [4:0]        feed_chunk,
   output logic              res_we,
   output logic [NEUR_W-1:0] res_idx,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   typedef enum logic [2:0] {
      IDLE, FC1_ISSUE, FC1_DRAIN, FC2_ISSUE, FC2_DRAIN, FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [4:0]        fc1_chunks_q;
   logic [2:0]        fc2_chunks_q;
   logic [NEUR_W-1:0] fc1_neur_q, fc2_neur_q;
   logic [4:0]        chunk_q;
   logic [NEUR_W-1:0] neuron_q, res_cnt_q;
   logic              cfg_err_q;

   logic              cfg_ok, accept, reject, in_fc1, in_fc2, issuing;
   logic [4:0]        cur_chunks;
   logic [NEUR_W-1:0] cur_neur;
   logic              last_chunk, last_neuron, last_issue, res_hit, last_result;

   always_comb begin
      cfg_ok      = (cfg_fc1_chunks != '0) && (cfg_fc2_chunks != '0) &&
                    (cfg_fc1_neurons != '0) && (cfg_fc2_neurons != '0);
      accept      = (state_q == IDLE) && start && cfg_ok;
      reject      = (state_q == IDLE) && start && !cfg_ok;
      in_fc1      = (state_q == FC1_ISSUE) || (state_q == FC1_DRAIN);
      in_fc2      = (state_q == FC2_ISSUE) || (state_q == FC2_DRAIN);
      issuing     = ((state_q == FC1_ISSUE) || (state_q == FC2_ISSUE)) && feed_ready;
      cur_chunks  = in_fc2 ? {2'b00, fc2_chunks_q} : fc1_chunks_q;
      cur_neur    = in_fc2 ? fc2_neur_q : fc1_neur_q;
      last_chunk  = (chunk_q == cur_chunks - 5'd1);
      last_neuron = (neuron_q == cur_neur - NEUR_W'(1));
      last_issue  = issuing && last_chunk && last_neuron;
      res_hit     = data_valid && (in_fc1 || in_fc2);
      last_result = res_hit && (res_cnt_q == cur_neur - NEUR_W'(1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept)      state_d = FC1_ISSUE;
         FC1_ISSUE: if (last_issue)  state_d = FC1_DRAIN;
         FC1_DRAIN: if (last_result) state_d = FC2_ISSUE;
         FC2_ISSUE: if (last_issue)  state_d = FC2_DRAIN;
         FC2_DRAIN: if (last_result) state_d = FINISH;
         FINISH:                     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         fc1_chunks_q <= '0;
         fc2_chunks_q <= '0;
         fc1_neur_q   <= '0;
         fc2_neur_q   <= '0;
         chunk_q      <= '0;
         neuron_q     <= '0;
         res_cnt_q    <= '0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= reject;
         if (accept) begin
            fc1_chunks_q <= cfg_fc1_chunks;
            fc2_chunks_q <= cfg_fc2_chunks;
            fc1_neur_q   <= cfg_fc1_neurons;
            fc2_neur_q   <= cfg_fc2_neurons;
            chunk_q      <= '0;
            neuron_q     <= '0;
            res_cnt_q    <= '0;
         end else if ((state_q == FC1_DRAIN) && last_result) begin
            chunk_q   <= '0;
            neuron_q  <= '0;
            res_cnt_q <= '0;
         end else begin
            // issue and result tracking are independent and may both fire
            if (issuing) begin
               if (last_chunk) begin
                  chunk_q  <= '0;
                  neuron_q <= neuron_q + NEUR_W'(1);
               end else begin
                  chunk_q <= chunk_q + 5'd1;
               end
            end
            if (res_hit) res_cnt_q <= res_cnt_q + NEUR_W'(1);
         end
      end
   end

   assign fully_1      = in_fc1;
   assign fully_2      = in_fc2;
   assign fc1_max_loop = fc1_chunks_q;
   assign fc2_max_loop = fc2_chunks_q;
   assign start_adder  = issuing;
   assign feed_neuron  = neuron_q;
   assign feed_chunk   = chunk_q;
   assign res_we       = res_hit;
   assign res_idx      = res_cnt_q;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == FINISH);
   assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_se_fc_sequencer.sv
// Scoreboard bench for se_fc_sequencer: expected issues/results are queued by
// the stimulus, a negedge monitor pops and compares whenever the DUT strobes.
module tb_se_fc_sequencer;
   localparam int NEUR_W = 10;

   logic              clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [4:0]        cfg_fc1_chunks = '0;
   logic [2:0]        cfg_fc2_chunks = '0;
   logic [NEUR_W-1:0] cfg_fc1_neurons = '0, cfg_fc2_neurons = '0;
   logic              feed_ready = 1'b0, data_valid = 1'b0;
   logic              fully_1, fully_2, start_adder, res_we, busy, done, cfg_err;
   logic [4:0]        fc1_max_loop, feed_chunk;
   logic [2:0]        fc2_max_loop;
   logic [NEUR_W-1:0] feed_neuron, res_idx;

   se_fc_sequencer #(.NEUR_W(NEUR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_fc1_chunks(cfg_fc1_chunks), .cfg_fc2_chunks(cfg_fc2_chunks),
      .cfg_fc1_neurons(cfg_fc1_neurons), .cfg_fc2_neurons(cfg_fc2_neurons),
      .feed_ready(feed_ready), .data_valid(data_valid),
      .fully_1(fully_1), .fully_2(fully_2),
      .fc1_max_loop(fc1_max_loop), .fc2_max_loop(fc2_max_loop),
      .start_adder(start_adder), .feed_neuron(feed_neuron), .feed_chunk(feed_chunk),
      .res_we(res_we), .res_idx(res_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct { int layer; int a; int b; } ent_t;
   ent_t iss_q[$];
   ent_t res_q[$];
   int   dv_due[$];

   int checks = 0, failures = 0;
   int cyc = 0;
   int done_exp = 0, done_seen = 0, err_seen = 0;
   int m_c1 = 1, m_n1 = 1, m_c2 = 1, m_n2 = 1, m_issues = 0;
   bit ready_toggle = 1'b0, force_dv = 1'b0;
   logic              prev_f1 = 1'b0, prev_f2 = 1'b0, prev_iss = 1'b0;
   logic [NEUR_W-1:0] prev_neur = '0;
   logic [4:0]        prev_chunk = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input longint act);
      checks++;
      failures++;
      $display("FAIL %s: got %0d expected no such event (t=%0t)", name, act, $time);
   endtask

   // input driver: feed_ready pattern and modelled adder (5-cycle sum latency)
   always @(posedge clk) begin
      logic dv;
      #1;
      cyc++;
      feed_ready = ready_toggle ? ~feed_ready : 1'b1;
      dv = force_dv;
      while (dv_due.size() > 0 && dv_due[0] <= cyc) begin
         if (dv_due[0] == cyc) dv = 1'b1;
         void'(dv_due.pop_front());
      end
      data_valid = dv;
   end

   // monitor and scoreboard
   always @(negedge clk) begin
      ent_t e;
      int   i;
      bit   lastc;
      chk("no_overlap", fully_1 & fully_2, 0);
      if ((prev_f1 && fully_1 || prev_f2 && fully_2) && !prev_iss)
         chk("freeze", {feed_neuron, feed_chunk}, {prev_neur, prev_chunk});
      if (start_adder) begin
         if (iss_q.size() == 0) fail_now("issue_unexpected", {feed_neuron, feed_chunk});
         else begin
            e = iss_q.pop_front();
            chk("issue_layer", fully_2 ? 2 : (fully_1 ? 1 : 0), e.layer);
            chk("issue_neuron", feed_neuron, e.a);
            chk("issue_chunk", feed_chunk, e.b);
         end
         i = m_issues;
         m_issues++;
         if (i < m_c1 * m_n1) lastc = ((i % m_c1) == m_c1 - 1);
         else                 lastc = (((i - m_c1 * m_n1) % m_c2) == m_c2 - 1);
         if (lastc) dv_due.push_back(cyc + 5);
      end
      if (res_we) begin
         if (res_q.size() == 0) fail_now("res_we_unexpected", res_idx);
         else begin
            e = res_q.pop_front();
            chk("res_layer", fully_2 ? 2 : (fully_1 ? 1 : 0), e.layer);
            chk("res_idx", res_idx, e.a);
         end
      end
      if (done) done_seen++;
      if (cfg_err) err_seen++;
      prev_f1 = fully_1; prev_f2 = fully_2; prev_iss = start_adder;
      prev_neur = feed_neuron; prev_chunk = feed_chunk;
   end

   task automatic push_seq(input int c1, input int n1, input int c2, input int n2);
      for (int n = 0; n < n1; n++) begin
         for (int c = 0; c < c1; c++) iss_q.push_back('{1, n, c});
         res_q.push_back('{1, n, 0});
      end
      for (int n = 0; n < n2; n++) begin
         for (int c = 0; c < c2; c++) iss_q.push_back('{2, n, c});
         res_q.push_back('{2, n, 0});
      end
      m_c1 = c1; m_n1 = n1; m_c2 = c2; m_n2 = n2; m_issues = 0;
      done_exp++;
   endtask

   task automatic pulse_start(input int c1, input int n1, input int c2, input int n2);
      @(posedge clk); #1;
      cfg_fc1_chunks  = 5'(c1);
      cfg_fc2_chunks  = 3'(c2);
      cfg_fc1_neurons = NEUR_W'(n1);
      cfg_fc2_neurons = NEUR_W'(n2);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done_seen < done_exp && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_seen < done_exp) fail_now({name, "_timeout"}, n);
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_iss_left"}, iss_q.size(), 0);
      chk({name, "_res_left"}, res_q.size(), 0);
      chk({name, "_done_cnt"}, done_seen, done_exp);
      chk({name, "_busy_end"}, busy, 0);
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_fully", {fully_1, fully_2}, 0);
      chk("rst_start_adder", start_adder, 0);
      chk("rst_max_loop", {fc1_max_loop, fc2_max_loop}, 0);
      chk("rst_feed", {feed_neuron, feed_chunk}, 0);
      chk("rst_done_err", {done, cfg_err, res_we}, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // basic run: fc1 2x3, fc2 1x2
      push_seq(2, 3, 1, 2);
      pulse_start(2, 3, 1, 2);
      chk("max_loop_fc1", fc1_max_loop, 2);
      chk("max_loop_fc2", fc2_max_loop, 1);
      chk("busy_run", busy, 1);
      wait_done("basic");

      // feed_ready toggling stalls the counters without losing chunks
      ready_toggle = 1'b1;
      push_seq(3, 2, 2, 1);
      pulse_start(3, 2, 2, 1);
      wait_done("toggle");
      ready_toggle = 1'b0;

      // zero cfg rejected
      pulse_start(2, 3, 1, 0);
      repeat (4) begin
         @(negedge clk);
         chk("err_busy", busy, 0);
         chk("err_issue", start_adder, 0);
      end
      chk("err_pulses", err_seen, 1);

      // second start during FC1_DRAIN is ignored
      push_seq(2, 3, 1, 2);
      pulse_start(2, 3, 1, 2);
      begin
         int n;
         n = 0;
         while (m_issues < 6 && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         if (m_issues < 6) fail_now("drain_timeout", m_issues);
      end
      chk("drain_fully_1", fully_1, 1);
      chk("drain_no_issue", start_adder, 0);
      pulse_start(7, 4, 5, 9);
      chk("ignored_fc1_loop", fc1_max_loop, 2);
      chk("ignored_fc2_loop", fc2_max_loop, 1);
      wait_done("restart");
      chk("err_after_ignore", err_seen, 1);

      // reset asserted mid FC2_ISSUE
      push_seq(2, 2, 3, 2);
      pulse_start(2, 2, 3, 2);
      begin
         int n;
         n = 0;
         while (m_issues < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         if (m_issues < 5) fail_now("fc2_timeout", m_issues);
      end
      chk("pre_rst_fully_2", fully_2, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_fully_2", fully_2, 0);
      chk("mid_rst_start_adder", start_adder, 0);
      chk("mid_rst_max_loop", {fc1_max_loop, fc2_max_loop}, 0);
      chk("mid_rst_feed", {feed_neuron, feed_chunk}, 0);
      iss_q.delete();
      res_q.delete();
      dv_due.delete();
      m_issues = 0;
      done_exp--;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", busy, 0);
      push_seq(2, 3, 1, 2);
      pulse_start(2, 3, 1, 2);
      wait_done("post_rst");

      // data_valid in IDLE does nothing
      @(posedge clk); #1;
      force_dv = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_res_we", res_we, 0);
         chk("idle_busy", busy, 0);
      end
      @(posedge clk); #1;
      force_dv = 1'b0;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
      $fatal(1, "timeout");
   end
endmodule
